// File: rtl/baud_tick_generator.sv
// Fractional-divisor UART oversample tick and bit tick generator with runtime divisor reload.
// Define BAUD_TICK_SYNC_EN to add the i_sync phase-align input.
module baud_tick_generator #(
    parameter real CLK_FREQ   = 100E6,
    parameter int  BAUD_RATE  = 9600,
    parameter int  OVERSAMPLE = 16,
    parameter int  DIV_NBITS  = 16,
    parameter int  FRAC_NBITS = 4
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_en,
    input  logic [DIV_NBITS+FRAC_NBITS-1:0] i_div,
    input  logic                            i_div_valid,
`ifdef BAUD_TICK_SYNC_EN
    input  logic                            i_sync,
`endif
    output logic                            o_div_pending,
    output logic                            o_tick,
    output logic                            o_bit_tick
);

    localparam int DW   = DIV_NBITS + FRAC_NBITS;
    localparam int OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam real D0_REAL = CLK_FREQ * real'(2 ** FRAC_NBITS) / real'(OVERSAMPLE * BAUD_RATE);
    localparam logic [DW-1:0]        DIV0    = DW'($rtoi(D0_REAL + 0.5));
    localparam logic [DIV_NBITS-1:0] ONE     = DIV_NBITS'(1);
    localparam logic [OS_W-1:0]      OS_ONE  = OS_W'(1);
    localparam logic [OS_W-1:0]      OS_LAST = OS_W'(OVERSAMPLE - 1);

    // Integer parts below 2 would give a zero-length period and stall the counter.
    function automatic logic [DIV_NBITS-1:0] clamp_int(input logic [DW-1:0] d);
        logic [DIV_NBITS-1:0] v;
        v = d[DW-1:FRAC_NBITS];
        return (v < DIV_NBITS'(2)) ? DIV_NBITS'(2) : v;
    endfunction

    logic [DW-1:0]         act_div;
    logic [DW-1:0]         stg_div;
    logic                  pending;
    logic [DIV_NBITS-1:0]  cnt;
    logic [FRAC_NBITS-1:0] frac_acc;
    logic [OS_W-1:0]       os_cnt;
    logic                  tick;
    logic                  bit_tick;

    logic                  at_zero;
    logic                  apply;
    logic                  sync_req;
    logic [DW-1:0]         new_div;
    logic [DIV_NBITS-1:0]  act_int;
    logic [DIV_NBITS-1:0]  new_int;
    logic [FRAC_NBITS:0]   frac_sum;
    logic [DIV_NBITS-1:0]  reload_val;
    logic [DIV_NBITS-1:0]  sync_val;

`ifdef BAUD_TICK_SYNC_EN
    assign sync_req = i_sync & i_en;
`else
    assign sync_req = 1'b0;
`endif

    // A load on the reload cycle itself bypasses the staging register.
    always_comb begin
        at_zero    = (cnt == '0);
        apply      = i_div_valid | pending;
        new_div    = i_div_valid ? i_div : stg_div;
        act_int    = clamp_int(act_div);
        new_int    = clamp_int(new_div);
        frac_sum   = {1'b0, frac_acc} + {1'b0, act_div[FRAC_NBITS-1:0]};
        reload_val = apply ? (new_int - ONE)
                           : (act_int - ONE + DIV_NBITS'(frac_sum[FRAC_NBITS]));
        sync_val   = apply ? (new_int - ONE) : (act_int - ONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            act_div  <= DIV0;
            stg_div  <= DIV0;
            pending  <= 1'b0;
            cnt      <= clamp_int(DIV0) - ONE;
            frac_acc <= '0;
            os_cnt   <= '0;
            tick     <= 1'b0;
            bit_tick <= 1'b0;
        end else if (sync_req) begin
            cnt      <= sync_val;
            frac_acc <= '0;
            os_cnt   <= '0;
            tick     <= 1'b0;
            bit_tick <= 1'b0;
            pending  <= 1'b0;
            if (apply) act_div <= new_div;
            if (i_div_valid) stg_div <= i_div;
        end else if (i_en && at_zero) begin
            tick     <= 1'b1;
            bit_tick <= (os_cnt == OS_LAST);
            os_cnt   <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_ONE;
            cnt      <= reload_val;
            if (i_div_valid) stg_div <= i_div;
            if (apply) begin
                act_div  <= new_div;
                frac_acc <= '0;
                pending  <= 1'b0;
            end else begin
                frac_acc <= frac_sum[FRAC_NBITS-1:0];
            end
        end else begin
            tick     <= 1'b0;
            bit_tick <= 1'b0;
            if (i_en) cnt <= cnt - ONE;
            if (i_div_valid) begin
                stg_div <= i_div;
                pending <= 1'b1;
            end
        end
    end

    assign o_tick        = tick;
    assign o_bit_tick    = bit_tick;
    assign o_div_pending = pending;

endmodule

// File: tb/tb_baud_tick_generator.sv
// Self-checking bench for baud_tick_generator: period-sum reference model plus directed timing checks.
// The sync scenario is compiled in only when BAUD_TICK_SYNC_EN is defined.
module tb_baud_tick_generator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic [19:0] div = '0;
    logic        div_valid = 1'b0;
`ifdef BAUD_TICK_SYNC_EN
    logic        sync = 1'b0;
`endif
    logic        o_div_pending;
    logic        o_tick;
    logic        o_bit_tick;

    localparam logic [19:0] D0 = 20'd10417;   // 651 + 1/16

    baud_tick_generator dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_en         (en),
        .i_div        (div),
        .i_div_valid  (div_valid),
`ifdef BAUD_TICK_SYNC_EN
        .i_sync       (sync),
`endif
        .o_div_pending(o_div_pending),
        .o_tick       (o_tick),
        .o_bit_tick   (o_bit_tick)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit chk = 1'b0;
    int tick_times[$];
    int bit_times[$];

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Reference model: tracks the enabled-cycle index at which each period ends.
    // Period k after a divisor takes effect is int + (floor(k*f/16) - floor((k-1)*f/16)).
    logic [19:0] m_act, m_stg;
    bit m_pend, m_tick, m_bit;
    int m_os, m_n, m_idx, m_end;

    function automatic int ic(input logic [19:0] d);
        int v;
        v = int'(d[19:4]);
        return (v < 2) ? 2 : v;
    endfunction

    function automatic int fr(input logic [19:0] d);
        return int'(d[3:0]);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_act = D0; m_stg = D0; m_pend = 0; m_tick = 0; m_bit = 0;
            m_os = 0; m_n = 0; m_idx = 0; m_end = ic(D0);
        end else begin
            m_tick = 0;
            m_bit  = 0;
`ifdef BAUD_TICK_SYNC_EN
            if (sync && en) begin
                if (div_valid) begin m_act = div; m_stg = div; end
                else if (m_pend) m_act = m_stg;
                m_pend = 0; m_n = 0; m_os = 0; m_idx = 0; m_end = ic(m_act);
            end else
`endif
            if (en && (m_idx + 1 == m_end)) begin
                m_idx  = m_idx + 1;
                m_tick = 1;
                m_bit  = (m_os == 15);
                m_os   = (m_os + 1) % 16;
                if (div_valid || m_pend) begin
                    m_act = div_valid ? div : m_stg;
                    if (div_valid) m_stg = div;
                    m_pend = 0;
                    m_n = 0;
                    m_end = m_end + ic(m_act);
                end else begin
                    m_n = m_n + 1;
                    m_end = m_end + ic(m_act) + ((m_n * fr(m_act)) >> 4)
                            - (((m_n - 1) * fr(m_act)) >> 4);
                end
            end else begin
                if (en) m_idx = m_idx + 1;
                if (div_valid) begin m_stg = div; m_pend = 1; end
            end
        end
    end

    always @(negedge clk) begin
        if (chk) begin
            vectors++;
            if ({o_tick, o_bit_tick, o_div_pending} !== {m_tick, m_bit, m_pend}) begin
                miscompares++;
                $display("FAIL model cycle %0d: tick/bit/pend got %b%b%b want %b%b%b",
                         cyc + 1, o_tick, o_bit_tick, o_div_pending, m_tick, m_bit, m_pend);
            end
            if (o_tick === 1'b1)     tick_times.push_back(cyc + 1);
            if (o_bit_tick === 1'b1) bit_times.push_back(cyc + 1);
        end
    end

    task automatic check(input string name, input int got, input int want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [19:0] d);
        div = d;
        div_valid = 1'b1;
        step();
        div_valid = 1'b0;
    endtask

    task automatic clear_q();
        tick_times.delete();
        bit_times.delete();
    endtask

    task automatic wait_ticks(input string name, input int n, input int budget);
        int k = 0;
        while (tick_times.size() < n && k < budget) begin
            step();
            k++;
        end
        if (tick_times.size() < n) begin
            vectors++;
            miscompares++;
            $display("FAIL %s timeout: got %0d ticks want %0d", name, tick_times.size(), n);
        end
    endtask

    function automatic int tt(input int i);
        return (i < tick_times.size()) ? tick_times[i] : -1;
    endfunction

    function automatic int bt(input int i);
        return (i < bit_times.size()) ? bit_times[i] : -1;
    endfunction

    initial begin
        step();
        chk = 1'b1;
        step();
        rst = 1'b0;

        // Default divisor: 15 x 651, then 652; bit tick on the 16th tick
        wait_ticks("default", 17, 12000);
        check("first_tick", tt(0), 652);
        check("period_1", tt(1) - tt(0), 651);
        check("period_16", tt(16) - tt(15), 652);
        check("span_16", tt(16) - tt(0), 10417);
        check("first_bit_tick", bt(0), 10417);

        // {4,0} loaded mid-period
        repeat (100) step();
        load({16'd4, 4'd0});
        clear_q();
        @(negedge clk);
        check("pend_set", int'(o_div_pending), 1);
        wait_ticks("div4", 40, 2000);
        check("div4_period", tt(2) - tt(1), 4);
        check("div4_span", tt(39) - tt(1), 152);
        check("div4_bit", bt(1) - bt(0), 64);

        // {0,0} clamps to a 2-cycle period
        load(20'd0);
        clear_q();
        wait_ticks("div0", 10, 200);
        check("div0_period", tt(2) - tt(1), 2);
        check("div0_span", tt(9) - tt(1), 16);

        // {10,8}: alternating 10/11, then a 7-cycle enable gap
        load({16'd10, 4'd8});
        clear_q();
        wait_ticks("div10_8", 22, 1000);
        check("frac_p1", tt(2) - tt(1), 10);
        check("frac_p2", tt(3) - tt(2), 11);
        check("frac_span20", tt(21) - tt(1), 210);
        step();
        step();
        en = 1'b0;
        repeat (7) step();
        check("en_hold_ticks", tick_times.size(), 22);
        en = 1'b1;
        wait_ticks("en_resume", 23, 100);
        check("en_gap_period", tt(22) - tt(21), 17);

        // Reset with a staged divisor mid-period
        load({16'd4, 4'd0});
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_q();
        @(negedge clk);
        check("rst_pend", int'(o_div_pending), 0);
        check("rst_tick", int'(o_tick), 0);
        wait_ticks("after_rst", 2, 1400);
        check("rst_first_tick", tt(0), 652);
        check("rst_d0_period", tt(1) - tt(0), 651);

`ifdef BAUD_TICK_SYNC_EN
        begin
            int s;
            load({16'd8, 4'd0});
            clear_q();
            wait_ticks("sync_setup", 2, 1000);
            step();
            step();
            sync = 1'b1;
            s = cyc + 1;
            clear_q();
            step();
            sync = 1'b0;
            wait_ticks("sync", 17, 300);
            // Sync acts like a silent reload: the counter restarts at int-1.
            check("sync_first", tt(0) - s, 9);
            check("sync_period", tt(1) - tt(0), 8);
            check("sync_bit", bt(0), tt(15));
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
